// File: rtl/fft_spi_stream.sv
// fft_spi_stream: on start, snapshots the FFT result bus and streams one framed
// packet (header, sequence number, sign-extended payload words, XOR checksum) over SPI mode 0.
module fft_spi_stream #(
  parameter int         N                 = 16,
  parameter int         MSB               = 8,
  parameter int         CLKS_PER_HALF_BIT = 2,
  parameter logic [7:0] HEADER            = 8'hA5
) (
  input  logic               clk,
  input  logic               rst_l,
  input  logic [N*2*MSB-1:0] data_bus,
  input  logic               start_spi,
  input  logic               half,
  output logic               sclk,
  output logic               mosi,
  output logic               cs,
  output logic               busy,
  output logic               done
);

  localparam int BPW = (MSB + 7) / 8;
  localparam int EW  = BPW * 8;
  localparam int NW  = 2 * N;
  localparam int WW  = (NW > 1) ? $clog2(NW) : 1;
  localparam int SW  = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int CW  = (CLKS_PER_HALF_BIT > 1) ? $clog2(CLKS_PER_HALF_BIT) : 1;

  localparam logic [CW-1:0] CNT_MAX   = CW'(CLKS_PER_HALF_BIT - 1);
  localparam logic [WW-1:0] LAST_FULL = WW'(NW - 1);
  localparam logic [WW-1:0] LAST_HALF = WW'(N - 1);
  localparam logic [SW-1:0] SUB_MAX   = SW'(BPW - 1);

  typedef enum logic [1:0] {S_IDLE, S_LEAD, S_SHIFT} state_t;
  typedef enum logic [1:0] {P_HDR, P_SEQ, P_PAY, P_CHK} part_t;

  // Handshake: start_spi is a request taken only in IDLE and not on the done
  // cycle; busy covers the whole frame; done pulses once as the frame ends.
  state_t             state_q, state_d;
  part_t              part_q, part_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2:0]         bit_q, bit_d;
  logic [7:0]         sh_q, sh_d;
  logic [WW-1:0]      word_q, word_d;
  logic [SW-1:0]      sub_q, sub_d;
  logic [7:0]         chk_q, chk_d;
  logic [7:0]         seq_q, seq_d;
  logic [NW*MSB-1:0]  snap_q, snap_d;
  logic               half_q, half_d;
  logic               tail_q, tail_d;
  logic               sclk_q, sclk_d;
  logic               mosi_q, mosi_d;
  logic               cs_q, cs_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [WW-1:0]      nxt_word;
  logic [SW-1:0]      nxt_sub;
  logic [MSB-1:0]     word_val;
  logic [EW-1:0]      word_ext;
  logic [7:0]         pay_byte;
  logic               pay_last;
  logic               load_en;
  logic [7:0]         load_byte;

  assign sclk = sclk_q;
  assign mosi = mosi_q;
  assign cs   = cs_q;
  assign busy = busy_q;
  assign done = done_q;

  // Next payload byte: the word/byte indices after the current one, taken
  // from the snapshot and sign-extended to whole bytes, MS byte first.
  always_comb begin
    if (part_q == P_SEQ) begin
      nxt_word = '0;
      nxt_sub  = '0;
    end else if (sub_q == SUB_MAX) begin
      nxt_word = word_q + 1'b1;
      nxt_sub  = '0;
    end else begin
      nxt_word = word_q;
      nxt_sub  = sub_q + 1'b1;
    end
    word_val = '0;
    for (int i = 0; i < NW; i++) begin
      if (nxt_word == WW'(i)) begin
        word_val = snap_q[i*MSB +: MSB];
      end
    end
    word_ext = {EW{word_val[MSB-1]}};
    word_ext[MSB-1:0] = word_val;
    pay_byte = 8'(word_ext >> (8 * (BPW - 1 - int'(nxt_sub))));
    pay_last = (sub_q == SUB_MAX) && (word_q == (half_q ? LAST_HALF : LAST_FULL));
  end

  always_comb begin
    state_d   = state_q;
    part_d    = part_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    sh_d      = sh_q;
    word_d    = word_q;
    sub_d     = sub_q;
    chk_d     = chk_q;
    seq_d     = seq_q;
    snap_d    = snap_q;
    half_d    = half_q;
    tail_d    = tail_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    cs_d      = cs_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    load_en   = 1'b0;
    load_byte = '0;

    case (state_q)
      S_IDLE: begin
        if (start_spi && !done_q) begin
          state_d = S_LEAD;
          snap_d  = data_bus;
          half_d  = half;
          cs_d    = 1'b0;
          busy_d  = 1'b1;
          sclk_d  = 1'b0;
          cnt_d   = '0;
          bit_d   = 3'd0;
          part_d  = P_HDR;
          word_d  = '0;
          sub_d   = '0;
          chk_d   = '0;
          tail_d  = 1'b0;
          load_en   = 1'b1;
          load_byte = HEADER;
        end
      end

      S_LEAD: begin
        if (cnt_q == CNT_MAX) begin
          cnt_d   = '0;
          sclk_d  = 1'b1;
          state_d = S_SHIFT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_SHIFT: begin
        if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          cnt_d = '0;
          if (tail_q) begin
            // Hold period after the last falling edge has elapsed.
            state_d = S_IDLE;
            tail_d  = 1'b0;
            cs_d    = 1'b1;
            busy_d  = 1'b0;
            sclk_d  = 1'b0;
            mosi_d  = 1'b0;
            done_d  = 1'b1;
            seq_d   = seq_q + 8'd1;
          end else if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            sclk_d = 1'b0;
            if (bit_q != 3'd7) begin
              bit_d  = bit_q + 3'd1;
              sh_d   = {sh_q[6:0], sh_q[7]};
              mosi_d = sh_q[6];
            end else begin
              bit_d = 3'd0;
              case (part_q)
                P_HDR: begin
                  load_en   = 1'b1;
                  load_byte = seq_q;
                  part_d    = P_SEQ;
                end
                P_SEQ: begin
                  load_en   = 1'b1;
                  load_byte = pay_byte;
                  part_d    = P_PAY;
                  word_d    = nxt_word;
                  sub_d     = nxt_sub;
                  chk_d     = pay_byte;
                end
                P_PAY: begin
                  load_en = 1'b1;
                  if (pay_last) begin
                    load_byte = chk_q;
                    part_d    = P_CHK;
                  end else begin
                    load_byte = pay_byte;
                    word_d    = nxt_word;
                    sub_d     = nxt_sub;
                    chk_d     = chk_q ^ pay_byte;
                  end
                end
                default: begin
                  tail_d = 1'b1;
                end
              endcase
            end
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (load_en) begin
      sh_d   = load_byte;
      mosi_d = load_byte[7];
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q <= S_IDLE;
      part_q  <= P_HDR;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      sh_q    <= '0;
      word_q  <= '0;
      sub_q   <= '0;
      chk_q   <= '0;
      seq_q   <= '0;
      snap_q  <= '0;
      half_q  <= 1'b0;
      tail_q  <= 1'b0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      cs_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      part_q  <= part_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      word_q  <= word_d;
      sub_q   <= sub_d;
      chk_q   <= chk_d;
      seq_q   <= seq_d;
      snap_q  <= snap_d;
      half_q  <= half_d;
      tail_q  <= tail_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      cs_q    <= cs_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_fft_spi_stream.sv
// Bench for fft_spi_stream: two instances (8-bit/H=1 and 12-bit/H=2), table-driven
// frames decoded from the SPI pins, plus back-to-back, busy-start and mid-frame reset sequences.
module tb_fft_spi_stream;

  typedef struct {
    bit               which;
    logic             hf;
    logic [3:0][11:0] w;
    int               nb;
    logic [8:0][7:0]  eb;
    bit               scr;
    bit               poke;
  } vec_t;

  vec_t tbl[$];

  logic        clk = 1'b0;
  logic        rst_l;
  logic [31:0] a_data;
  logic        a_start, a_half, a_sclk, a_mosi, a_cs, a_busy, a_done;
  logic [47:0] b_data;
  logic        b_start, b_half, b_sclk, b_mosi, b_cs, b_busy, b_done;

  bit   sel;
  logic m_sclk, m_mosi, m_cs, m_busy, m_done;

  always #5 clk = ~clk;

  fft_spi_stream #(.N(2), .MSB(8), .CLKS_PER_HALF_BIT(1), .HEADER(8'hA5)) dut_a (
    .clk(clk), .rst_l(rst_l), .data_bus(a_data), .start_spi(a_start), .half(a_half),
    .sclk(a_sclk), .mosi(a_mosi), .cs(a_cs), .busy(a_busy), .done(a_done)
  );

  fft_spi_stream #(.N(2), .MSB(12), .CLKS_PER_HALF_BIT(2), .HEADER(8'hA5)) dut_b (
    .clk(clk), .rst_l(rst_l), .data_bus(b_data), .start_spi(b_start), .half(b_half),
    .sclk(b_sclk), .mosi(b_mosi), .cs(b_cs), .busy(b_busy), .done(b_done)
  );

  assign m_sclk = sel ? b_sclk : a_sclk;
  assign m_mosi = sel ? b_mosi : a_mosi;
  assign m_cs   = sel ? b_cs   : a_cs;
  assign m_busy = sel ? b_busy : a_busy;
  assign m_done = sel ? b_done : a_done;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  function automatic void check(input string name, input longint got, input longint exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endfunction

  function automatic void add_vec(input bit which, input logic hf, input logic [47:0] w,
                                  input int nb, input logic [71:0] eb, input bit scr, input bit poke);
    vec_t v;
    v.which = which; v.hf = hf; v.w = w; v.nb = nb; v.eb = eb; v.scr = scr; v.poke = poke;
    tbl.push_back(v);
  endfunction

  task automatic set_inputs(input bit which, input logic hf, input logic [3:0][11:0] w);
    if (which) begin
      b_half = hf;
      b_data = {w[3], w[2], w[1], w[0]};
    end else begin
      a_half = hf;
      a_data = {w[3][7:0], w[2][7:0], w[1][7:0], w[0][7:0]};
    end
  endtask

  task automatic set_start(input bit which, input logic v);
    if (which) b_start = v;
    else a_start = v;
  endtask

  // Frame capture results.
  logic [7:0] got_q[$];
  int rise_n, rise_bad, done_rel, done_n, cs_low, m0_viol;
  bit start_ok, timed_out;

  // Observed at the falling clk edge, rel = 0 is the cycle right after the
  // accepting edge, so a pin value the timing table gives at t0+k shows up at rel k-1.
  task automatic run_frame(input vec_t v);
    int unsigned t0, rel;
    int h;
    logic psclk, pmosi;
    logic [7:0] cur;
    int nbits;
    logic [3:0][11:0] rw;
    h = v.which ? 2 : 1;
    sel = v.which;
    got_q.delete();
    rise_n = 0; rise_bad = 0; done_rel = -1; done_n = 0; cs_low = 0; m0_viol = 0;
    timed_out = 1'b1;
    @(negedge clk);
    set_inputs(v.which, v.hf, v.w);
    set_start(v.which, 1'b1);
    t0 = cyc + 1;
    @(negedge clk);
    set_start(v.which, 1'b0);
    start_ok = (m_cs == 1'b0) && (m_busy == 1'b1) && (m_sclk == 1'b0) && (m_mosi == 1'b1);
    psclk = 1'b0; pmosi = m_mosi; cur = '0; nbits = 0;
    for (int i = 0; i < 3000; i++) begin
      rel = cyc - t0;
      if (v.scr) begin
        for (int k = 0; k < 4; k++) rw[k] = 12'($urandom_range(0, 4095));
        set_inputs(v.which, 1'($urandom_range(0, 1)), rw);
      end
      if (v.poke) set_start(v.which, (rel % 17) == 5);
      if (!m_cs) cs_low++;
      if (m_sclk && psclk && (m_mosi != pmosi)) m0_viol++;
      if (m_sclk && !psclk) begin
        if (rel != h + 2 * h * rise_n) rise_bad++;
        rise_n++;
        cur = {cur[6:0], m_mosi};
        nbits++;
        if (nbits == 8) begin
          got_q.push_back(cur);
          nbits = 0;
        end
      end
      psclk = m_sclk;
      pmosi = m_mosi;
      if (m_done) begin
        done_n++;
        done_rel = rel;
        timed_out = 1'b0;
        break;
      end
      @(negedge clk);
    end
    set_start(v.which, 1'b0);
  endtask

  task automatic check_frame(input vec_t v, input logic [7:0] seq);
    int h;
    logic [7:0] exp_b;
    h = v.which ? 2 : 1;
    check("frame_timeout", timed_out, 0);
    check("start_pins", start_ok, 1);
    check("byte_count", got_q.size(), v.nb);
    for (int j = 0; j < v.nb && j < got_q.size(); j++) begin
      if (j == 0) exp_b = 8'hA5;
      else if (j == 1) exp_b = seq;
      else exp_b = v.eb[10-j];
      check($sformatf("frame_byte%0d", j), got_q[j], exp_b);
    end
    check("sclk_rises", rise_n, 8 * v.nb);
    check("rise_timing_errors", rise_bad, 0);
    check("done_time", done_rel, 16 * h * v.nb + h);
    check("cs_low_cycles", cs_low, 16 * h * v.nb + h);
    check("mosi_change_while_sclk_high", m0_viol, 0);
  endtask

  logic [7:0] seq_a, seq_b;
  int bad_cs, bad_sclk, bad_mosi, bad_busy, bad_done, cnt;
  vec_t bv;

  initial begin
    rst_l = 1'b0;
    a_start = 1'b0; b_start = 1'b0; a_half = 1'b0; b_half = 1'b0;
    a_data = '0; b_data = '0;
    sel = 1'b0;
    seq_a = 8'd0; seq_b = 8'd0;

    // {dut, half, words w3..w0, bytes, payload+chk bytes first-to-last, scramble, busy pokes}
    add_vec(0, 0, {12'h008, 12'h004, 12'h002, 12'h001}, 7, 72'h01_02_04_08_0F_00_00_00_00, 0, 0);
    add_vec(0, 1, {12'h008, 12'h004, 12'h002, 12'h001}, 5, 72'h01_02_03_00_00_00_00_00_00, 0, 1);
    add_vec(0, 0, {12'h000, 12'h07F, 12'h080, 12'h0FF}, 7, 72'hFF_80_7F_00_00_00_00_00_00, 1, 0);
    add_vec(0, 0, {12'h011, 12'h0C3, 12'h03C, 12'h05A}, 7, 72'h5A_3C_C3_11_B4_00_00_00_00, 0, 0);
    add_vec(0, 1, {12'h0FF, 12'h0FF, 12'h018, 12'h0E7}, 5, 72'hE7_18_FF_00_00_00_00_00_00, 0, 0);
    add_vec(1, 1, {12'h123, 12'hFFF, 12'h07F, 12'h801}, 7, 72'hF8_01_00_7F_86_00_00_00_00, 0, 0);
    add_vec(1, 0, {12'h123, 12'hFFF, 12'h07F, 12'h801}, 11, 72'hF8_01_00_7F_FF_FF_01_23_A4, 1, 0);
    add_vec(1, 1, {12'h000, 12'h000, 12'h800, 12'h7FF}, 7, 72'h07_FF_F8_00_00_00_00_00_00, 0, 1);

    // Reset and idle.
    bad_cs = 0; bad_sclk = 0; bad_mosi = 0; bad_busy = 0; bad_done = 0;
    repeat (5) @(negedge clk);
    rst_l = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (a_cs !== 1'b1 || b_cs !== 1'b1) bad_cs++;
      if (a_sclk !== 1'b0 || b_sclk !== 1'b0) bad_sclk++;
      if (a_mosi !== 1'b0 || b_mosi !== 1'b0) bad_mosi++;
      if (a_busy !== 1'b0 || b_busy !== 1'b0) bad_busy++;
      if (a_done !== 1'b0 || b_done !== 1'b0) bad_done++;
    end
    check("idle_cs_high", bad_cs, 0);
    check("idle_sclk_low", bad_sclk, 0);
    check("idle_mosi_low", bad_mosi, 0);
    check("idle_busy_low", bad_busy, 0);
    check("idle_done_low", bad_done, 0);

    // Table frames, each followed by a start on the done cycle that must be ignored.
    foreach (tbl[i]) begin
      run_frame(tbl[i]);
      check_frame(tbl[i], tbl[i].which ? seq_b : seq_a);
      if (tbl[i].which) seq_b++;
      else seq_a++;
      set_start(tbl[i].which, 1'b1);
      @(negedge clk);
      set_start(tbl[i].which, 1'b0);
      check("done_one_cycle", m_done, 0);
      cnt = 0;
      repeat (20) begin
        @(negedge clk);
        if (!m_cs || m_busy) cnt++;
      end
      check("no_frame_after_ignored_start", cnt, 0);
    end

    // Back-to-back frames with stray starts while busy; sequence wraps 255 -> 0.
    bv = tbl[1];
    for (int k = 0; k < 257; k++) begin
      run_frame(bv);
      check("b2b_timeout", timed_out, 0);
      check("b2b_byte_count", got_q.size(), 5);
      if (got_q.size() > 1) check($sformatf("b2b_seq%0d", k), got_q[1], seq_a);
      seq_a++;
    end
    cnt = 0;
    repeat (30) begin
      @(negedge clk);
      if (!a_cs) cnt++;
    end
    check("no_extra_frame_after_b2b", cnt, 0);

    // Reset during payload byte 2 of a dut_a frame.
    sel = 1'b0;
    @(negedge clk);
    set_inputs(0, 1'b0, tbl[0].w);
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    repeat (66) @(negedge clk);
    check("midframe_cs_low_before_reset", a_cs, 0);
    rst_l = 1'b0;
    #1;
    check("reset_cs_high", a_cs, 1);
    check("reset_sclk_low", a_sclk, 0);
    check("reset_mosi_low", a_mosi, 0);
    check("reset_busy_low", a_busy, 0);
    @(negedge clk);
    rst_l = 1'b1;
    cnt = 0; bad_cs = 0;
    repeat (40) begin
      @(negedge clk);
      if (a_done) cnt++;
      if (!a_cs) bad_cs++;
    end
    check("reset_no_done", cnt, 0);
    check("reset_stays_idle", bad_cs, 0);
    seq_a = 8'd0;
    seq_b = 8'd0;
    run_frame(tbl[0]);
    check_frame(tbl[0], seq_a);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
